// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, x/y counters and decoded sync/blanking/strobe outputs.
// Optional 16-bit frame counter port out_frame is built when VGA_FRAME_COUNT_EN is defined.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned D_WIDTH  = 640,
  parameter int unsigned D_HEIGHT = 480,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        in_clock,
  input  logic        in_reset,
  input  logic        in_pause,
  output logic        out_pix_stb,
  output logic        out_hs,
  output logic        out_vs,
  output logic [11:0] out_x,
  output logic [11:0] out_y,
  output logic        out_active,
  output logic        out_animate,
  output logic        out_ani_stb,
  output logic        out_end_screen
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] out_frame
`endif
);

  localparam int unsigned H_TOTAL = D_WIDTH + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = D_HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [11:0] X_ACT  = 12'(D_WIDTH);
  localparam logic [11:0] HS_BEG = 12'(D_WIDTH + H_FP);
  localparam logic [11:0] HS_END = 12'(D_WIDTH + H_FP + H_SYNC);
  localparam logic [11:0] X_MAX  = 12'(H_TOTAL - 1);
  localparam logic [11:0] Y_ACT  = 12'(D_HEIGHT);
  localparam logic [11:0] VS_BEG = 12'(D_HEIGHT + V_FP);
  localparam logic [11:0] VS_END = 12'(D_HEIGHT + V_FP + V_SYNC);
  localparam logic [11:0] Y_MAX  = 12'(V_TOTAL - 1);

  logic [DIV_W-1:0] r_div;
  logic [11:0]      r_x;
  logic [11:0]      r_y;
  logic             w_pix_stb;
  logic             w_x_wrap;
  logic             w_end_screen;

  // With CLK_DIV=1 the divider sits at 0 == DIV_MAX, so the strobe is held high.
  assign w_pix_stb    = (r_div == DIV_MAX);
  assign w_x_wrap     = (r_x == X_MAX);
  assign w_end_screen = w_pix_stb && w_x_wrap && (r_y == Y_MAX);

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_div <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      r_div <= w_pix_stb ? '0 : r_div + 1'b1;
      if (w_pix_stb) begin
        if (w_x_wrap) begin
          r_x <= '0;
          r_y <= (r_y == Y_MAX) ? '0 : r_y + 12'd1;
        end else begin
          r_x <= r_x + 12'd1;
        end
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame;

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_frame <= '0;
    end else if (w_end_screen) begin
      r_frame <= r_frame + 16'd1;
    end
  end

  assign out_frame = r_frame;
`endif

  assign out_pix_stb    = w_pix_stb;
  assign out_x          = r_x;
  assign out_y          = r_y;
  assign out_hs         = !((r_x >= HS_BEG) && (r_x < HS_END));
  assign out_vs         = !((r_y >= VS_BEG) && (r_y < VS_END));
  assign out_active     = (r_x < X_ACT) && (r_y < Y_ACT);
  assign out_animate    = (r_y >= Y_ACT);
  assign out_ani_stb    = w_pix_stb && (r_x == 12'd0) && (r_y == Y_ACT) && !in_pause;
  assign out_end_screen = w_end_screen;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (23x12, CLK_DIV=4) plus a CLK_DIV=1 instance.
module tb_vga_timing_gen;

  localparam int unsigned CDIV = 4;
  localparam int unsigned DW = 16, DH = 8, HFP = 2, HSY = 3, HBP = 2;
  localparam int unsigned VFP = 1, VSY = 2, VBP = 1;
  localparam int unsigned HT = DW + HFP + HSY + HBP;  // 23
  localparam int unsigned VT = DH + VFP + VSY + VBP;  // 12

  typedef struct packed {
    logic        stb, hs, vs, act, anim, ani, endf;
    logic [11:0] x, y;
  } out_t;

  typedef struct {
    int unsigned n;
    logic        pause;
    out_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, pause;
  int unsigned n;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic s0, h0, v0, a0, m0, k0, e0, s1, h1, v1, a1, m1, k1, e1;
  logic [11:0] x0, y0, x1, y1;
  out_t g0, g1;
  assign g0 = {s0, h0, v0, a0, m0, k0, e0, x0, y0};
  assign g1 = {s1, h1, v1, a1, m1, k1, e1, x1, y1};
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] f0, f1;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(.CLK_DIV(CDIV), .D_WIDTH(DW), .D_HEIGHT(DH), .H_FP(HFP), .H_SYNC(HSY),
                   .H_BP(HBP), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) u0 (
    .in_clock(clk), .in_reset(rst), .in_pause(pause), .out_pix_stb(s0), .out_hs(h0),
    .out_vs(v0), .out_x(x0), .out_y(y0), .out_active(a0), .out_animate(m0),
    .out_ani_stb(k0), .out_end_screen(e0)
`ifdef VGA_FRAME_COUNT_EN
    , .out_frame(f0)
`endif
  );

  vga_timing_gen #(.CLK_DIV(1), .D_WIDTH(DW), .D_HEIGHT(DH), .H_FP(HFP), .H_SYNC(HSY),
                   .H_BP(HBP), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) u1 (
    .in_clock(clk), .in_reset(rst), .in_pause(pause), .out_pix_stb(s1), .out_hs(h1),
    .out_vs(v1), .out_x(x1), .out_y(y1), .out_active(a1), .out_animate(m1),
    .out_ani_stb(k1), .out_end_screen(e1)
`ifdef VGA_FRAME_COUNT_EN
    , .out_frame(f1)
`endif
  );

  // Reference: position is just (completed pixel strobes) mod frame size, n = edges since reset.
  function automatic out_t model(input int unsigned cyc, input int unsigned cdiv, input logic pz);
    out_t o;
    int unsigned p, pos, x, y;
    p   = cyc / cdiv;
    pos = p % (HT * VT);
    x   = pos % HT;
    y   = pos / HT;
    o.stb  = ((cyc % cdiv) == cdiv - 1);
    o.hs   = !(x >= DW + HFP && x < DW + HFP + HSY);
    o.vs   = !(y >= DH + VFP && y < DH + VFP + VSY);
    o.act  = (x < DW) && (y < DH);
    o.anim = (y >= DH);
    o.ani  = o.stb && x == 0 && y == DH && !pz;
    o.endf = o.stb && x == HT - 1 && y == VT - 1;
    o.x    = 12'(x);
    o.y    = 12'(y);
    return o;
  endfunction

  function automatic vec_t mk(input int unsigned cyc, input logic pz, input logic stb, input logic hs,
                              input logic vs, input logic act, input logic anim, input logic ani,
                              input logic endf, input int unsigned x, input int unsigned y);
    vec_t v;
    v.n = cyc;
    v.pause = pz;
    v.exp = {stb, hs, vs, act, anim, ani, endf, 12'(x), 12'(y)};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n = rst ? 0 : n + 1;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  vec_t tbl[20];
  int unsigned cnt, ecnt, ax, ay;
  bit first;

  initial begin
    rst = 1'b1;
    pause = 1'b0;
    n = 0;
    //            n    pz stb hs vs act anim ani end  x   y
    tbl[0]  = mk(0,    0, 0, 1, 1, 1, 0, 0, 0, 0,  0);
    tbl[1]  = mk(3,    0, 1, 1, 1, 1, 0, 0, 0, 0,  0);
    tbl[2]  = mk(4,    0, 0, 1, 1, 1, 0, 0, 0, 1,  0);
    tbl[3]  = mk(7,    0, 1, 1, 1, 1, 0, 0, 0, 1,  0);
    tbl[4]  = mk(11,   0, 1, 1, 1, 1, 0, 0, 0, 2,  0);
    tbl[5]  = mk(60,   0, 0, 1, 1, 1, 0, 0, 0, 15, 0);
    tbl[6]  = mk(64,   0, 0, 1, 1, 0, 0, 0, 0, 16, 0);
    tbl[7]  = mk(71,   0, 1, 1, 1, 0, 0, 0, 0, 17, 0);
    tbl[8]  = mk(72,   0, 0, 0, 1, 0, 0, 0, 0, 18, 0);
    tbl[9]  = mk(83,   0, 1, 0, 1, 0, 0, 0, 0, 20, 0);
    tbl[10] = mk(84,   0, 0, 1, 1, 0, 0, 0, 0, 21, 0);
    tbl[11] = mk(91,   0, 1, 1, 1, 0, 0, 0, 0, 22, 0);
    tbl[12] = mk(92,   0, 0, 1, 1, 1, 0, 0, 0, 0,  1);
    tbl[13] = mk(739,  0, 1, 1, 1, 0, 1, 1, 0, 0,  8);
    tbl[14] = mk(739,  1, 1, 1, 1, 0, 1, 0, 0, 0,  8);
    tbl[15] = mk(828,  0, 0, 1, 0, 0, 1, 0, 0, 0,  9);
    tbl[16] = mk(920,  0, 0, 1, 0, 0, 1, 0, 0, 0,  10);
    tbl[17] = mk(1012, 0, 0, 1, 1, 0, 1, 0, 0, 0,  11);
    tbl[18] = mk(1103, 0, 1, 1, 1, 0, 1, 0, 1, 22, 11);
    tbl[19] = mk(1104, 0, 0, 1, 1, 1, 0, 0, 0, 0,  0);

    for (int unsigned i = 0; i < 20; i++) begin
      pause = tbl[i].pause;
      reset_dut();
      repeat (tbl[i].n) tick();
      #1;
      chk($sformatf("tbl%0d", i), 32'(g0), 32'(tbl[i].exp));
    end

    // Reset while both syncs are low: everything returns to origin on the next edge.
    pause = 1'b0;
    reset_dut();
    repeat (908) tick();
    chk("pre_rst_pos", {8'd0, x0, y0}, {8'd0, 12'd20, 12'd9});
    chk("pre_rst_sync", {30'd0, h0, v0}, 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst", 32'(g0), 32'(model(0, CDIV, 1'b0)));
    chk("mid_rst_sync", {30'd0, h0, v0}, 32'd3);
    rst = 1'b0;

    // One line: hsync low for exactly HSY strobes, beginning at x=DW+HFP.
    reset_dut();
    cnt = 0;
    first = 1'b1;
    ax = 0;
    for (int unsigned i = 0; i < HT * CDIV; i++) begin
      if (s0 && !h0) begin
        cnt++;
        if (first) ax = x0;
        first = 1'b0;
      end
      tick();
    end
    chk("hs_strobes", cnt, HSY);
    chk("hs_first_x", ax, DW + HFP);
    chk("line_wrap", {8'd0, x0, y0}, {8'd0, 12'd0, 12'd1});

    // Full frames, unpaused then paused.
    for (int unsigned pz = 0; pz < 2; pz++) begin
      pause = pz[0];
      reset_dut();
      cnt = 0;
      ecnt = 0;
      ax = 99;
      ay = 99;
      for (int unsigned i = 0; i < HT * VT * CDIV; i++) begin
        if (k0) begin
          cnt++;
          ax = x0;
          ay = y0;
        end
        if (e0) ecnt++;
        tick();
      end
      chk($sformatf("ani_count_p%0d", pz), cnt, (pz == 0) ? 1 : 0);
      chk($sformatf("end_count_p%0d", pz), ecnt, 1);
      if (pz == 0) chk("ani_pos", {ax[15:0], ay[15:0]}, {16'd0, 16'(DH)});
      chk($sformatf("frame_wrap_p%0d", pz), {8'd0, x0, y0}, 32'd0);
    end

    // CLK_DIV=1: strobe held high, including during reset.
    pause = 1'b0;
    rst = 1'b1;
    #1;
    chk("div1_in_reset", 32'(s1), 32'd1);
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (s1) cnt++;
      tick();
    end
    chk("div1_stb_count", cnt, 50);
    chk("div1_x", 32'(x1), 32'd50 % HT);

    // Random pause / occasional reset against the reference model, every cycle.
    reset_dut();
    for (int unsigned i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 63) == 0) pause = ~pause;
      rst = ($urandom_range(0, 2999) == 0);
      #1;
      chk("rnd_div4", 32'(g0), 32'(model(n, CDIV, pause)));
      chk("rnd_div1", 32'(g1), 32'(model(n, 1, pause)));
`ifdef VGA_FRAME_COUNT_EN
      chk("rnd_frame4", 32'(f0), (n / CDIV / (HT * VT)) % 65536);
      chk("rnd_frame1", 32'(f1), (n / (HT * VT)) % 65536);
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
